tdoa_calc: RTL and testbench

Time-difference-of-arrival estimator for one microphone pair.
- Accumulates a sign-coincidence cross-correlation over a fixed window of sample pairs and selects the best lag as a 4-bit delay code `TD`.
- Flags whether the frame was loud enough (`THRES`).
- Toggles `CALC_FREE` once per finished frame; the downstream register packer captures `TD`/`THRES` on that toggle.
- Sits directly upstream of the packer, between the microphone sample front-end and the PS-facing 32-bit result word.

---
 rtl/tdoa_pkg.sv | 17 +
 rtl/lag_corr_bank.sv | 61 ++++++
 rtl/tdoa_calc.sv | 114 +++++++++++
 tb/tb_tdoa_calc.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdoa_pkg.sv
// Shared constants and types for the tdoa_calc time-difference-of-arrival estimator.
package tdoa_pkg;

    localparam int MAX_LAG   = 7;
    localparam int N_LAGS    = 2 * MAX_LAG + 1;
    localparam int TD_CENTER = MAX_LAG;

    typedef logic [3:0] td_t;

    typedef enum logic [1:0] {
        ACCUM,
        SEARCH,
        POST,
        TOGGLE
    } state_e;

endpackage

// File: rtl/lag_corr_bank.sv
// Sign delay lines and per-lag sign-coincidence accumulators for tdoa_calc.
// Accumulator k holds the count for lag k-MAX_LAG and is read back through rdIdx_i.
module lag_corr_bank
    import tdoa_pkg::*;
#(
    parameter int ACC_W = 9
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             sign0_i,
    input  logic             sign1_i,
    input  logic             clear_i,
    input  logic             accEn_i,
    input  td_t              rdIdx_i,
    output logic [ACC_W-1:0] rdData_o
);

    // Tap i holds the sign from i+1 samples ago; both lines meet at the centre tap.
    logic [N_LAGS-1:0] line0_q;
    logic [N_LAGS-1:0] line1_q;
    logic [N_LAGS-1:0] coincide;
    logic [ACC_W-1:0]  acc_q [N_LAGS];

    always_comb begin
        coincide = '0;
        for (int k = 0; k < N_LAGS; k++) begin
            if (k < TD_CENTER) begin
                coincide[k] = ~(line0_q[MAX_LAG] ^ line1_q[2*MAX_LAG-k]);
            end else begin
                coincide[k] = ~(line1_q[MAX_LAG] ^ line0_q[k]);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line0_q <= '0;
            line1_q <= '0;
            for (int k = 0; k < N_LAGS; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            if (valid_i) begin
                line0_q <= {line0_q[N_LAGS-2:0], sign0_i};
                line1_q <= {line1_q[N_LAGS-2:0], sign1_i};
            end
            for (int k = 0; k < N_LAGS; k++) begin
                if (clear_i) begin
                    acc_q[k] <= '0;
                end else if (accEn_i && coincide[k]) begin
                    acc_q[k] <= acc_q[k] + ACC_W'(1);
                end
            end
        end
    end

    assign rdData_o = (rdIdx_i < td_t'(N_LAGS)) ? acc_q[rdIdx_i] : '0;

endmodule

// File: rtl/tdoa_calc.sv
// Sign-coincidence TDOA estimator for one microphone pair; posts TD/THRES and toggles CALC_FREE per frame.
// Optional macro TDOA_QUIET_GATE_EN forces TD to the zero-lag code when the frame had no loud sample.
module tdoa_calc
    import tdoa_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int N_LOG2   = 8,
    parameter int THRESH   = 2048
)
(
    input  logic                       SCK,
    input  logic                       RST,
    input  logic signed [SAMPLE_W-1:0] S0,
    input  logic signed [SAMPLE_W-1:0] S1,
    input  logic                       VALID,
    output td_t                        TD,
    output logic                       THRES,
    output logic                       CALC_FREE
);

    localparam int                  ACC_W    = N_LOG2 + 1;
    localparam logic [SAMPLE_W-2:0] THRESH_V = (SAMPLE_W-1)'(THRESH);

    // The most negative sample has no positive twin, so it saturates to all-ones.
    function automatic logic [SAMPLE_W-2:0] magSat(input logic [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-2:0] lo;
        lo = x[SAMPLE_W-2:0];
        if (!x[SAMPLE_W-1]) return lo;
        if (lo == '0) return '1;
        return ~lo + (SAMPLE_W-1)'(1);
    endfunction

    state_e            state_q;
    logic [N_LOG2-1:0] frameCnt_q;
    logic              peak_q;
    td_t               idx_q;
    logic [ACC_W-1:0]  best_q;
    td_t               bestIdx_q;
    logic [ACC_W-1:0]  rdData;
    logic              accept;
    logic              loud;

    assign accept = VALID && (state_q == ACCUM);
    assign loud   = (magSat(S0) >= THRESH_V) || (magSat(S1) >= THRESH_V);

    lag_corr_bank #(
        .ACC_W (ACC_W)
    ) u_bank (
        .clk_i    (SCK),
        .rst_i    (RST),
        .valid_i  (VALID),
        .sign0_i  (S0[SAMPLE_W-1]),
        .sign1_i  (S1[SAMPLE_W-1]),
        .clear_i  (state_q == TOGGLE),
        .accEn_i  (accept),
        .rdIdx_i  (idx_q),
        .rdData_o (rdData)
    );

    always_ff @(posedge SCK or posedge RST) begin
        if (RST) begin
            state_q    <= ACCUM;
            frameCnt_q <= '0;
            peak_q     <= 1'b0;
            idx_q      <= '0;
            best_q     <= '0;
            bestIdx_q  <= '0;
            TD         <= '0;
            THRES      <= 1'b0;
            CALC_FREE  <= 1'b1;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (VALID) begin
                        frameCnt_q <= frameCnt_q + N_LOG2'(1);
                        if (loud) peak_q <= 1'b1;
                        if (frameCnt_q == '1) begin
                            state_q   <= SEARCH;
                            idx_q     <= '0;
                            best_q    <= '0;
                            bestIdx_q <= '0;
                        end
                    end
                end
                // Strictly-greater replacement keeps the lowest TD on ties.
                SEARCH: begin
                    if (rdData > best_q) begin
                        best_q    <= rdData;
                        bestIdx_q <= idx_q;
                    end
                    idx_q <= idx_q + td_t'(1);
                    if (idx_q == td_t'(N_LAGS - 1)) state_q <= POST;
                end
                POST: begin
`ifdef TDOA_QUIET_GATE_EN
                    TD <= peak_q ? bestIdx_q : td_t'(TD_CENTER);
`else
                    TD <= bestIdx_q;
`endif
                    THRES   <= peak_q;
                    state_q <= TOGGLE;
                end
                TOGGLE: begin
                    CALC_FREE  <= ~CALC_FREE;
                    frameCnt_q <= '0;
                    peak_q     <= 1'b0;
                    state_q    <= ACCUM;
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_tdoa_calc.sv
// Self-checking bench for tdoa_calc: randomized delayed-sign streams against an argmax reference model.
module tb_tdoa_calc;
    import tdoa_pkg::*;

    localparam int FRAME = 256;
    localparam int TH    = 2048;
    localparam int LAT   = 17;
    // Each accepted sample correlates sign history that sits ALIGN samples behind it.
    localparam int ALIGN = 8;

    logic               SCK   = 1'b0;
    logic               RST   = 1'b1;
    logic signed [15:0] S0    = '0;
    logic signed [15:0] S1    = '0;
    logic               VALID = 1'b0;
    td_t                TD;
    logic               THRES;
    logic               CALC_FREE;

    int   nCompared   = 0;
    int   nMismatched = 0;
    logic expCalcFree = 1'b1;
    logic signed [15:0] hist0[$];
    logic signed [15:0] hist1[$];
    logic signed [15:0] src[$];

    tdoa_calc #(
        .SAMPLE_W (16),
        .N_LOG2   (8),
        .THRESH   (TH)
    ) dut (
        .SCK       (SCK),
        .RST       (RST),
        .S0        (S0),
        .S1        (S1),
        .VALID     (VALID),
        .TD        (TD),
        .THRES     (THRES),
        .CALC_FREE (CALC_FREE)
    );

    always #5 SCK = ~SCK;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Drive one VALID sample at the falling edge and log it for the model.
    task automatic applyStimulus(input logic signed [15:0] a, input logic signed [15:0] b);
        @(negedge SCK);
        S0 = a;
        S1 = b;
        VALID = 1'b1;
        hist0.push_back(a);
        hist1.push_back(b);
    endtask

    function automatic logic signed [15:0] srcAt(input int i);
        if (i < 0) return '0;
        return src[i];
    endfunction

    // d > 0: MIC1 lags MIC0 by d samples; d < 0: MIC1 leads by -d samples.
    task automatic sendPair(input int d, input int amp, input bit randMag, input bit useForced,
                            input logic signed [15:0] forcedVal);
        int m;
        int v;
        int last;
        logic signed [15:0] r;
        if (useForced) begin
            r = forcedVal;
        end else begin
            m = randMag ? int'($urandom_range(amp, 0)) : amp;
            v = ($urandom_range(1, 0) == 1) ? -m : m;
            r = 16'(v);
        end
        src.push_back(r);
        last = src.size() - 1;
        if (d >= 0) applyStimulus(src[last], srcAt(last - d));
        else        applyStimulus(srcAt(last + d), src[last]);
    endtask

    task automatic sendFrame(input int d, input int amp, input bit randMag, input int loudAt,
                             output int start);
        start = hist0.size();
        for (int n = 0; n < FRAME; n++) begin
            sendPair(d, amp, randMag, n == loudAt, 16'sh8000);
        end
    endtask

    task automatic doReset();
        @(negedge SCK);
        RST = 1'b1;
        VALID = 1'b0;
        S0 = '0;
        S1 = '0;
        repeat (2) @(negedge SCK);
        RST = 1'b0;
        hist0.delete();
        hist1.delete();
        src.delete();
        expCalcFree = 1'b1;
    endtask

    // lat = cycles from the last accepted sample to the CALC_FREE toggle, -1 if none within the bound.
    task automatic waitToggle(input int maxCycles, output int lat);
        lat = -1;
        for (int n = 1; n <= maxCycles; n++) begin
            @(negedge SCK);
            VALID = 1'b0;
            if (CALC_FREE !== expCalcFree) begin
                lat = n - 1;
                break;
            end
        end
    endtask

    function automatic bit sgn(input int which, input int i);
        if (i < 0) return 1'b0;
        return (which == 0) ? hist0[i][15] : hist1[i][15];
    endfunction

    function automatic int magOf(input logic signed [15:0] x);
        int v;
        v = x;
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    // Reference: count sign agreements per lag over the frame, take the first maximum.
    task automatic modelFrame(input int start, output td_t td, output logic thr);
        int cnt;
        int best;
        int bestLag;
        thr = 1'b0;
        for (int p = start; p < start + FRAME; p++) begin
            if (magOf(hist0[p]) >= TH || magOf(hist1[p]) >= TH) thr = 1'b1;
        end
        best = -1;
        bestLag = 0;
        for (int lag = -MAX_LAG; lag <= MAX_LAG; lag++) begin
            cnt = 0;
            for (int p = start; p < start + FRAME; p++) begin
                if (lag >= 0) cnt += (sgn(1, p - ALIGN) == sgn(0, p - ALIGN - lag)) ? 1 : 0;
                else          cnt += (sgn(0, p - ALIGN) == sgn(1, p - ALIGN + lag)) ? 1 : 0;
            end
            if (cnt > best) begin
                best = cnt;
                bestLag = lag;
            end
        end
        td = td_t'(TD_CENTER + bestLag);
`ifdef TDOA_QUIET_GATE_EN
        if (!thr) td = td_t'(TD_CENTER);
`endif
    endtask

    task automatic test_reset();
        @(negedge SCK);
        RST = 1'b1;
        repeat (2) @(negedge SCK);
        nCompared++;
        if ({TD, THRES, CALC_FREE} !== {4'd0, 1'b0, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL reset_hold: got TD=%0d THRES=%0b CALC_FREE=%0b, want 0/0/1", TD, THRES, CALC_FREE);
        end
        doReset();
        for (int c = 0; c < 300; c++) begin
            @(negedge SCK);
            nCompared++;
            if ({TD, THRES, CALC_FREE} !== {4'd0, 1'b0, 1'b1}) begin
                nMismatched++;
                $display("[TB] FAIL idle_after_reset cycle %0d: got TD=%0d THRES=%0b CALC_FREE=%0b, want 0/0/1",
                         c, TD, THRES, CALC_FREE);
            end
        end
    endtask

    task automatic test_delay3();
        int start;
        int lat;
        td_t mTd;
        logic mThr;
        doReset();
        sendFrame(3, 1000, 1'b0, -1, start);
        waitToggle(40, lat);
        expCalcFree = ~expCalcFree;
        modelFrame(start, mTd, mThr);
        nCompared += 5;
        if (lat !== LAT) begin
            nMismatched++;
            $display("[TB] FAIL delay3_latency: got %0d, want %0d", lat, LAT);
        end
        if (TD !== td_t'(10)) begin
            nMismatched++;
            $display("[TB] FAIL delay3_td: got %0d, want 10", TD);
        end
        if (TD !== mTd) begin
            nMismatched++;
            $display("[TB] FAIL delay3_td_model: got %0d, want %0d", TD, mTd);
        end
        if (THRES !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL delay3_thres: got %0b, want 0", THRES);
        end
        if (CALC_FREE !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL delay3_calc_free: got %0b, want 0", CALC_FREE);
        end
        for (int c = 0; c < 50; c++) @(negedge SCK);
        nCompared++;
        if ({TD, THRES, CALC_FREE} !== {td_t'(10), 1'b0, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL delay3_stable: got TD=%0d THRES=%0b CF=%0b, want 10/0/0", TD, THRES, CALC_FREE);
        end
    endtask

    task automatic test_delay7_pair();
        int start;
        int lat;
        td_t mTd;
        logic mThr;
        int dl[2];
        logic [3:0] wantTd[2];
        dl[0] = 7;
        dl[1] = -7;
        wantTd[0] = 4'd14;
        wantTd[1] = 4'd0;
        doReset();
        for (int f = 0; f < 2; f++) begin
            sendFrame(dl[f], 1000, 1'b0, -1, start);
            waitToggle(40, lat);
            expCalcFree = ~expCalcFree;
            modelFrame(start, mTd, mThr);
            nCompared += 4;
            if (lat !== LAT) begin
                nMismatched++;
                $display("[TB] FAIL delay7_latency[%0d]: got %0d, want %0d", f, lat, LAT);
            end
            if (TD !== wantTd[f]) begin
                nMismatched++;
                $display("[TB] FAIL delay7_td[%0d]: got %0d, want %0d", f, TD, wantTd[f]);
            end
            if (TD !== mTd) begin
                nMismatched++;
                $display("[TB] FAIL delay7_td_model[%0d]: got %0d, want %0d", f, TD, mTd);
            end
            if (CALC_FREE !== expCalcFree) begin
                nMismatched++;
                $display("[TB] FAIL delay7_calc_free[%0d]: got %0b, want %0b", f, CALC_FREE, expCalcFree);
            end
        end
    endtask

    task automatic test_loud();
        int start;
        int lat;
        td_t mTd;
        logic mThr;
        sendFrame(3, 1000, 1'b0, 50, start);
        waitToggle(40, lat);
        expCalcFree = ~expCalcFree;
        modelFrame(start, mTd, mThr);
        nCompared += 4;
        if (lat !== LAT) begin
            nMismatched++;
            $display("[TB] FAIL loud_latency: got %0d, want %0d", lat, LAT);
        end
        if (THRES !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL loud_thres: got %0b, want 1", THRES);
        end
        if (TD !== td_t'(10)) begin
            nMismatched++;
            $display("[TB] FAIL loud_td: got %0d, want 10", TD);
        end
        if (TD !== mTd || THRES !== mThr) begin
            nMismatched++;
            $display("[TB] FAIL loud_model: got TD=%0d THRES=%0b, want %0d/%0b", TD, THRES, mTd, mThr);
        end
    endtask

    task automatic test_reset_midframe();
        int lat;
        td_t mTd;
        logic mThr;
        for (int n = 0; n < 100; n++) sendPair(3, 1000, 1'b0, 1'b0, '0);
        @(negedge SCK);
        VALID = 1'b0;
        RST = 1'b1;
        @(negedge SCK);
        nCompared++;
        if ({TD, THRES, CALC_FREE} !== {4'd0, 1'b0, 1'b1}) begin
            nMismatched++;
            $display("[TB] FAIL midreset_values: got TD=%0d THRES=%0b CF=%0b, want 0/0/1", TD, THRES, CALC_FREE);
        end
        RST = 1'b0;
        hist0.delete();
        hist1.delete();
        src.delete();
        expCalcFree = 1'b1;
        for (int n = 0; n < FRAME - 1; n++) sendPair(3, 1000, 1'b0, 1'b0, '0);
        waitToggle(40, lat);
        nCompared++;
        if (lat !== -1 || CALC_FREE !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL midreset_early_post: got latency %0d CF=%0b, want no toggle and CF=1", lat, CALC_FREE);
        end
        sendPair(3, 1000, 1'b0, 1'b0, '0);
        waitToggle(40, lat);
        expCalcFree = ~expCalcFree;
        modelFrame(0, mTd, mThr);
        nCompared += 2;
        if (lat !== LAT) begin
            nMismatched++;
            $display("[TB] FAIL midreset_latency: got %0d, want %0d", lat, LAT);
        end
        if (TD !== mTd || TD !== td_t'(10) || THRES !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL midreset_result: got TD=%0d THRES=%0b, want %0d/0", TD, THRES, mTd);
        end
    endtask

    task automatic test_zero();
        int lat;
        td_t mTd;
        logic mThr;
        td_t wantTd;
`ifdef TDOA_QUIET_GATE_EN
        wantTd = td_t'(TD_CENTER);
`else
        wantTd = td_t'(0);
`endif
        doReset();
        for (int n = 0; n < FRAME; n++) applyStimulus('0, '0);
        waitToggle(40, lat);
        expCalcFree = ~expCalcFree;
        modelFrame(0, mTd, mThr);
        nCompared += 3;
        if (TD !== wantTd || TD !== mTd) begin
            nMismatched++;
            $display("[TB] FAIL zero_td: got %0d, want %0d", TD, wantTd);
        end
        if (THRES !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL zero_thres: got %0b, want 0", THRES);
        end
        if (lat !== LAT || CALC_FREE !== expCalcFree) begin
            nMismatched++;
            $display("[TB] FAIL zero_toggle: got latency %0d CF=%0b, want %0d/%0b", lat, CALC_FREE, LAT, expCalcFree);
        end
    endtask

    task automatic test_random_frames();
        int start;
        int lat;
        int d;
        int amp;
        td_t mTd;
        logic mThr;
        for (int f = 0; f < 4; f++) begin
            d = int'($urandom_range(14, 0)) - MAX_LAG;
            amp = (f % 2 == 0) ? 4000 : 1500;
            sendFrame(d, amp, 1'b1, -1, start);
            waitToggle(40, lat);
            expCalcFree = ~expCalcFree;
            modelFrame(start, mTd, mThr);
            nCompared += 3;
            if (TD !== mTd) begin
                nMismatched++;
                $display("[TB] FAIL random_td[%0d] lag %0d: got %0d, want %0d", f, d, TD, mTd);
            end
            if (THRES !== mThr) begin
                nMismatched++;
                $display("[TB] FAIL random_thres[%0d]: got %0b, want %0b", f, THRES, mThr);
            end
            if (lat !== LAT || CALC_FREE !== expCalcFree) begin
                nMismatched++;
                $display("[TB] FAIL random_toggle[%0d]: got latency %0d CF=%0b, want %0d/%0b",
                         f, lat, CALC_FREE, LAT, expCalcFree);
            end
        end
    endtask

    // VALID never drops: the 17 samples during search/post/toggle shift history but are not counted.
    task automatic test_back_to_back();
        int start;
        int d;
        td_t mTd;
        logic mThr;
        for (int f = 0; f < 3; f++) begin
            d = int'($urandom_range(14, 0)) - MAX_LAG;
            start = hist0.size();
            for (int n = 0; n < FRAME; n++) begin
                sendPair(d, 1000, 1'b0, 1'b0, '0);
                if (f > 0 && n == 0) begin
                    nCompared++;
                    if (CALC_FREE !== expCalcFree) begin
                        nMismatched++;
                        $display("[TB] FAIL b2b_toggle[%0d]: got %0b, want %0b", f, CALC_FREE, expCalcFree);
                    end
                end
            end
            for (int k = 0; k < LAT; k++) sendPair(d, 1000, 1'b0, 1'b0, '0);
            modelFrame(start, mTd, mThr);
            nCompared += 2;
            if (TD !== mTd || TD !== td_t'(TD_CENTER + d) || THRES !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL b2b_result[%0d] lag %0d: got TD=%0d THRES=%0b, want %0d/0", f, d, TD, THRES, mTd);
            end
            if (CALC_FREE !== expCalcFree) begin
                nMismatched++;
                $display("[TB] FAIL b2b_early_toggle[%0d]: got %0b, want %0b", f, CALC_FREE, expCalcFree);
            end
            expCalcFree = ~expCalcFree;
        end
        @(negedge SCK);
        VALID = 1'b0;
        nCompared++;
        if (CALC_FREE !== expCalcFree) begin
            nMismatched++;
            $display("[TB] FAIL b2b_last_toggle: got %0b, want %0b", CALC_FREE, expCalcFree);
        end
    endtask

    initial begin
        $display("[TB] tdoa_calc bench start");
        test_reset();
        test_delay3();
        test_delay7_pair();
        test_loud();
        test_reset_midframe();
        test_zero();
        test_random_frames();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
